// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder through one 4-bit ripple slice, one nibble per clock, LSB nibble first.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic            carry;
  logic [KW-1:0]   k;

  logic [3:0]      slice_s;
  logic            slice_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic            slice_c3;
`endif

  // The single 4-bit ripple slice; c is the carry rippling bit to bit.
  always_comb begin
    logic c;
    c = carry;
    slice_s = '0;
`ifdef SERIAL_ADDER_OVF_EN
    slice_c3 = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
`ifdef SERIAL_ADDER_OVF_EN
      if (i == 3) slice_c3 = c;
`endif
      slice_s[i] = a_reg[i] ^ b_reg[i] ^ c;
      c = (a_reg[i] & b_reg[i]) | (b_reg[i] & c) | (c & a_reg[i]);
    end
    slice_co = c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      k         <= '0;
      sum       <= '0;
      co        <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= ci;
            k        <= '0;
            sum      <= '0;
            co       <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf      <= 1'b0;
`endif
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[{k, 2'b00} +: 4] <= slice_s;
          carry <= slice_co;
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          if (k == KW'(N - 1)) begin
            k         <= '0;
            co        <= slice_co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= slice_c3 ^ slice_co;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          // Input is never taken here, even alongside the output handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder at WIDTH 8, 16 and 32.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;
  logic        ci;
  int          sel;

  logic        iv8, iv16, iv32;
  logic        ir8, ir16, ir32;
  logic        ov8, ov16, ov32;
  logic        co8, co16, co32;
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic [31:0] sum32;
  logic        rd_ir, rd_ov, rd_co;
  logic [31:0] rd_sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf8, ovf16, ovf32, rd_ovf;
`endif

  assign iv8  = in_valid && (sel == 8);
  assign iv16 = in_valid && (sel == 16);
  assign iv32 = in_valid && (sel == 32);

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]), .ci(ci),
    .out_valid(ov8), .out_ready(out_ready), .sum(sum8), .co(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a[15:0]), .b(b[15:0]), .ci(ci),
    .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .co(co16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b), .ci(ci),
    .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .co(co32)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf32)
`endif
  );

  always_comb begin
    rd_ir = ir16; rd_ov = ov16; rd_co = co16; rd_sum = {16'h0, sum16};
`ifdef SERIAL_ADDER_OVF_EN
    rd_ovf = ovf16;
    if (sel == 8)  rd_ovf = ovf8;
    if (sel == 32) rd_ovf = ovf32;
`endif
    if (sel == 8)  begin rd_ir = ir8;  rd_ov = ov8;  rd_co = co8;  rd_sum = {24'h0, sum8}; end
    if (sel == 32) begin rd_ir = ir32; rd_ov = ov32; rd_co = co32; rd_sum = sum32; end
  end

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;
  vec_t vecs[8];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (width %0d): got %0h expected %0h", name, sel, act, exp);
    end
  endtask

  // Reference: {ovf, co, sum} for a w-bit add.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] m, m1, s, s1;
    logic        cout, cmsb;
    m  = (33'h1 << w) - 33'h1;
    m1 = (33'h1 << (w - 1)) - 33'h1;
    s  = ({1'b0, x} & m) + ({1'b0, y} & m) + {32'h0, c};
    s1 = ({1'b0, x} & m1) + ({1'b0, y} & m1) + {32'h0, c};
    cout = s[w];
    cmsb = s1[w-1];
    return {cmsb ^ cout, cout, s[31:0] & m[31:0]};
  endfunction

  task automatic run_op(input int w, input logic [31:0] x, input logic [31:0] y, input logic c,
                        input logic [31:0] es, input logic eco, input logic eovf,
                        input int stall, input bit poke);
    int   waitc, lat;
    exp_t e;
    sel = w;
    waitc = 0;
    #1;
    while (!rd_ir && waitc < 20) begin @(posedge clk); #1; waitc++; end
    if (!rd_ir) begin check("in_ready_timeout", rd_ir, 1); return; end
    a = x; b = y; ci = c; in_valid = 1'b1; out_ready = 1'b0;
    e.sum = es; e.co = eco; e.ovf = eovf;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom);
    lat = 0;
    while (!rd_ov && lat < 64) begin @(posedge clk); #1; lat++; end
    check("latency", lat, w / 4);
    if (!rd_ov) begin void'(sb.pop_front()); return; end
    for (int i = 0; i < stall; i++) begin
      in_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      check("stall_out_valid", rd_ov, 1);
      check("stall_in_ready", rd_ir, 0);
      check("stall_sum", rd_sum, sb[0].sum);
      check("stall_co", rd_co, sb[0].co);
    end
    in_valid = poke;
    out_ready = 1'b1;
    e = sb.pop_front();
    check("sum", rd_sum, e.sum);
    check("co", rd_co, e.co);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", rd_ovf, e.ovf);
`endif
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("in_ready_after", rd_ir, 1);
    check("out_valid_after", rd_ov, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [33:0] r;
    logic [31:0] x, y;
    logic        c;
    bit          seen;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0; sel = 16;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (vecs[i]) begin end
    for (int w = 8; w <= 32; w = w * 2) begin
      sel = w; #1;
      check("reset_in_ready", rd_ir, 1);
      check("reset_out_valid", rd_ov, 0);
      check("reset_sum", rd_sum, 0);
      check("reset_co", rd_co, 0);
    end

    for (int i = 0; i < 8; i++)
      run_op(16, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].ci,
             {16'h0, vecs[i].s}, vecs[i].co, vecs[i].ovf, 0, 1'b0);

    // Back-pressure with ignored in_valid pulses, then simultaneous in_valid/out_ready.
    run_op(16, 32'hF000, 32'h1000, 1'b0, 32'h0000, 1'b1, 1'b0, 10, 1'b1);

    // Reset during the second RUN cycle.
    sel = 16; #1;
    a = 32'hAAAA; b = 32'h5555; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", rd_ir, 1);
    check("midrst_sum", rd_sum, 0);
    check("midrst_out_valid", rd_ov, 0);
    sb.delete();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rd_ov) seen = 1'b1;
    end
    check("midrst_no_out_valid", seen, 0);
    run_op(16, 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0, 0, 1'b0);

    for (int w = 8; w <= 32; w = w + 24) begin
      for (int n = 0; n < 1000; n++) begin
        x = $urandom; y = $urandom; c = 1'($urandom);
        if (n < 4) begin x = '1; y = (n[0]) ? 32'h0 : '1; c = 1'b1; end
        r = model(w, x, y, c);
        run_op(w, x, y, c, r[31:0], r[32], r[33],
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
